// File: rtl/fifo_conv_pkg.sv
// Shared types, default widths and ratio helper for the fifo_data_conv path
// (write-side packer and read-side unpacker).
package fifo_conv_pkg;

    localparam int WIDE_W_DEF   = 16;
    localparam int NARROW_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unpack_state_t;

    // Returns 0 for an illegal pairing so the caller can reject it at elaboration.
    function automatic int ratio(input int wide, input int narrow);
        if ((narrow <= 0) || ((wide % narrow) != 0)) begin
            ratio = 0;
        end else begin
            ratio = wide / narrow;
        end
    endfunction

endpackage

// File: rtl/fifo_rd_unpacker_if.sv
// FIFO read port plus narrow valid/ready stream bundle for fifo_rd_unpacker.
// master = unpacker side, slave = FIFO/downstream side.
interface fifo_rd_unpacker_if
    import fifo_conv_pkg::*;
#(
    parameter int WIDE_W   = WIDE_W_DEF,
    parameter int NARROW_W = NARROW_W_DEF
);
    logic                fifo_empty;
    logic [WIDE_W-1:0]   fifo_rdata;
    logic                fifo_rd;
    logic [NARROW_W-1:0] m_data;
    logic                m_valid;
    logic                m_ready;
    logic                m_last;
    logic                busy;

    modport master (
        input  fifo_empty, fifo_rdata, m_ready,
        output fifo_rd, m_data, m_valid, m_last, busy
    );

    modport slave (
        output fifo_empty, fifo_rdata, m_ready,
        input  fifo_rd, m_data, m_valid, m_last, busy
    );
endinterface

// File: rtl/fifo_rd_unpacker.sv
// Pops WIDE_W words from the FIFO and streams them as RATIO narrow beats.
// Optional macro FIFO_UNPACK_LSB_FIRST_EN selects LSB-first beat order (default MSB-first).
module fifo_rd_unpacker
    import fifo_conv_pkg::*;
#(
    parameter int WIDE_W   = WIDE_W_DEF,
    parameter int NARROW_W = NARROW_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    fifo_rd_unpacker_if.master bus
);

    localparam int RATIO = ratio(WIDE_W, NARROW_W);
    localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;

    if (RATIO < 2) begin : g_bad_ratio
        $error("fifo_rd_unpacker: WIDE_W must be a multiple of NARROW_W with ratio >= 2");
    end

    unpack_state_t        state_r;
    logic [WIDE_W-1:0]    shreg_r;
    logic [CNT_W-1:0]     beat_cnt_r;
    logic [NARROW_W-1:0]  m_data_r;
    logic                 m_valid_r;
    logic                 m_last_r;
    logic                 busy_r;
    logic                 handshake_s;
    logic                 pop_s;
    logic [CNT_W-1:0]     beat_next_s;

    // Beat 0 is the top slice unless the LSB-first build is selected.
    function automatic logic [NARROW_W-1:0] slice_f(input logic [WIDE_W-1:0] word,
                                                    input logic [CNT_W-1:0]  idx);
        int pos;
`ifdef FIFO_UNPACK_LSB_FIRST_EN
        pos = int'(idx);
`else
        pos = RATIO - 1 - int'(idx);
`endif
        slice_f = word[pos*NARROW_W +: NARROW_W];
    endfunction

    // Mealy pop strobe: never while empty, only when a new word can be taken.
    always_comb begin
        handshake_s = m_valid_r & bus.m_ready;
        beat_next_s = beat_cnt_r + CNT_W'(1);
        pop_s       = 1'b0;
        if (!reset_n || bus.fifo_empty) begin
            pop_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    pop_s = 1'b1;
                SEND:    pop_s = handshake_s & m_last_r;
                default: pop_s = 1'b0;
            endcase
        end
    end

    // FSM, shift register, beat counter and registered stream outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            shreg_r    <= '0;
            beat_cnt_r <= '0;
            m_data_r   <= '0;
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        shreg_r    <= bus.fifo_rdata;
                        beat_cnt_r <= '0;
                        m_data_r   <= slice_f(bus.fifo_rdata, CNT_W'(0));
                        m_valid_r  <= 1'b1;
                        m_last_r   <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= SEND;
                    end
                end
                SEND: begin
                    if (handshake_s && m_last_r && pop_s) begin
                        // zero-bubble refill: next word's first beat follows immediately
                        shreg_r    <= bus.fifo_rdata;
                        beat_cnt_r <= '0;
                        m_data_r   <= slice_f(bus.fifo_rdata, CNT_W'(0));
                        m_last_r   <= 1'b0;
                    end else if (handshake_s && m_last_r) begin
                        beat_cnt_r <= '0;
                        m_valid_r  <= 1'b0;
                        m_last_r   <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end else if (handshake_s) begin
                        beat_cnt_r <= beat_next_s;
                        m_data_r   <= slice_f(shreg_r, beat_next_s);
                        m_last_r   <= (beat_next_s == CNT_W'(RATIO - 1));
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    m_valid_r <= 1'b0;
                    m_last_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_rd = pop_s;
    assign bus.m_data  = m_data_r;
    assign bus.m_valid = m_valid_r;
    assign bus.m_last  = m_last_r;
    assign bus.busy    = busy_r;

endmodule
